// File: rtl/phy_rx_deserializer.sv
// Two-lane serial receiver: finds byte/word alignment from COM/SKP idle words, then emits one 32-bit word per 16 clk_32f.
// Word output updates on the edge sampling the last bit of the slot-1 bytes; no backpressure, idle words drop valid_out.
module phy_rx_deserializer #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  SKP        = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        Data_in_1bit_0,
  input  logic        Data_in_1bit_1,
  output logic [31:0] Data_out,
  output logic        valid_out,
  output logic        active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0]  SYNC_CNT  = 4'(SYNC_COUNT);
  localparam logic [31:0] IDLE_WORD = {COM, SKP, COM, SKP};

  state_t      state;
  logic [7:0]  sr0, sr1;
  logic [7:0]  hi0, hi1;
  logic [2:0]  bitcnt;
  logic        slot;
  logic [3:0]  idlecnt;

  logic [7:0]  cand0, cand1;
  logic [7:0]  expect_sym;
  logic        cand_match;
  logic        cand_com;
  logic        byte_end;
  logic [3:0]  idlecnt_nxt;
  logic [31:0] word;
  logic        word_idle;

  assign cand0       = {sr0[6:0], Data_in_1bit_0};
  assign cand1       = {sr1[6:0], Data_in_1bit_1};
  assign expect_sym  = slot ? SKP : COM;
  assign cand_match  = (cand0 == expect_sym) && (cand1 == expect_sym);
  assign cand_com    = (cand0 == COM) && (cand1 == COM);
  assign byte_end    = (bitcnt == 3'd7);
  assign idlecnt_nxt = idlecnt + 4'd1;
  assign word        = {hi0, cand0, hi1, cand1};
  assign word_idle   = (word == IDLE_WORD);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr0       <= '0;
      sr1       <= '0;
      hi0       <= '0;
      hi1       <= '0;
      bitcnt    <= '0;
      slot      <= 1'b0;
      idlecnt   <= '0;
      Data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr0 <= cand0;
      sr1 <= cand1;
      case (state)
        SEARCH: begin
          if (cand_com) begin
            state   <= ALIGN;
            bitcnt  <= '0;
            slot    <= 1'b1;
            idlecnt <= '0;
          end
        end
        ALIGN: begin
          bitcnt <= bitcnt + 3'd1;
          if (byte_end) begin
            slot <= ~slot;
            // A failed compare never re-detects COM on the same clock.
            if (!cand_match) begin
              state   <= SEARCH;
              idlecnt <= '0;
              bitcnt  <= '0;
              slot    <= 1'b0;
            end else if (slot) begin
              idlecnt <= idlecnt_nxt;
              if (idlecnt_nxt == SYNC_CNT) begin
                state  <= ACTIVE;
                active <= 1'b1;
                slot   <= 1'b0;
              end
            end
          end
        end
        ACTIVE: begin
          bitcnt <= bitcnt + 3'd1;
          if (byte_end) begin
            slot <= ~slot;
            if (!slot) begin
              hi0 <= cand0;
              hi1 <= cand1;
            end else begin
              valid_out <= ~word_idle;
              Data_out  <= word_idle ? 32'd0 : word;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: drives both serial lanes bit by bit and checks outputs every clock.
module tb_phy_rx_deserializer;

  localparam logic [31:0] IDLE = 32'hBC7CBC7C;

  logic        clk_32f;
  logic        reset;
  logic        d0, d1;
  logic [31:0] Data_out;
  logic        valid_out;
  logic        active;

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  phy_rx_deserializer dut (
    .clk_32f        (clk_32f),
    .reset          (reset),
    .Data_in_1bit_0 (d0),
    .Data_in_1bit_1 (d1),
    .Data_out       (Data_out),
    .valid_out      (valid_out),
    .active         (active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
  endtask

  task automatic chk_outs(input logic ea, input logic ev, input logic [31:0] ed);
    chk("active", {31'd0, active}, {31'd0, ea});
    chk("valid_out", {31'd0, valid_out}, {31'd0, ev});
    chk("Data_out", Data_out, ed);
  endtask

  // Outputs seen before driving each bit reflect everything up to the previous sampling edge.
  task automatic drive_bit(input logic b0, input logic b1,
                           input logic ea, input logic ev, input logic [31:0] ed);
    @(negedge clk_32f);
    chk_outs(ea, ev, ed);
    d0 = b0;
    d1 = b1;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic ea, input logic ev, input logic [31:0] ed);
    for (int i = 7; i >= 0; i--) drive_bit(w[24+i], w[8+i], ea, ev, ed);
    for (int i = 7; i >= 0; i--) drive_bit(w[16+i], w[i], ea, ev, ed);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_32f);
      chk_outs(1'b0, 1'b0, 32'd0);
      d0 = i[0];
      d1 = ~i[0];
    end
    @(negedge clk_32f);
    d0    = 1'b0;
    d1    = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] prefix;
    reset = 1'b0;
    d0    = 1'b0;
    d1    = 1'b1;

    phase = "reset";
    hold_reset(3);

    // Sync on four idle words, then four back-to-back data words.
    phase = "burst";
    for (int k = 0; k < 4; k++) send_word(IDLE, 1'b0, 1'b0, 32'd0);
    send_word(32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
    send_word(32'hEEEEEEEE, 1'b1, 1'b1, 32'hFFFFFFFF);
    send_word(32'hDDDDDDDD, 1'b1, 1'b1, 32'hEEEEEEEE);
    send_word(32'hCCCCCCCC, 1'b1, 1'b1, 32'hDDDDDDDD);
    send_word(IDLE,         1'b1, 1'b1, 32'hCCCCCCCC);
    send_word(IDLE,         1'b1, 1'b0, 32'd0);

    phase = "prefix";
    hold_reset(3);
    prefix = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) drive_bit(prefix[i], prefix[i], 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) send_word(IDLE, 1'b0, 1'b0, 32'd0);
    send_word(32'h00000003, 1'b1, 1'b0, 32'd0);
    send_word(32'h00000004, 1'b1, 1'b1, 32'h00000003);
    send_word(IDLE,         1'b1, 1'b1, 32'h00000004);
    send_word(IDLE,         1'b1, 1'b0, 32'd0);

    // Second SKP corrupted on lane 1: alignment must restart on the next COM.
    phase = "corrupt";
    hold_reset(3);
    send_word(IDLE,         1'b0, 1'b0, 32'd0);
    send_word(32'hBC7CBC7D, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) send_word(IDLE, 1'b0, 1'b0, 32'd0);
    send_word(32'hAAAAAAAA, 1'b1, 1'b0, 32'd0);
    send_word(IDLE,         1'b1, 1'b1, 32'hAAAAAAAA);
    send_word(IDLE,         1'b1, 1'b0, 32'd0);

    phase = "midreset";
    send_word(32'h12345678, 1'b1, 1'b0, 32'd0);
    for (int i = 7; i >= 3; i--) drive_bit(1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678);
    #3 reset = 1'b0;
    #1 chk_outs(1'b0, 1'b0, 32'd0);
    hold_reset(3);
    for (int k = 0; k < 4; k++) send_word(IDLE, 1'b0, 1'b0, 32'd0);
    send_word(32'h00000007, 1'b1, 1'b0, 32'd0);
    send_word(32'h00000008, 1'b1, 1'b1, 32'h00000007);

    phase = "near_idle";
    send_word(32'hBC7CBCBC, 1'b1, 1'b1, 32'h00000008);
    send_word(IDLE,         1'b1, 1'b1, 32'hBC7CBCBC);
    send_word(IDLE,         1'b1, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
